// File: rtl/spi_byte_sequencer.sv
// ---------------------------------------------------------------------------
// spi_byte_sequencer
//
// Purpose
//   Converts a byte stream into I/O strobe accesses on an SPI master that sits
//   on the same clock. Every accepted byte becomes one write strobe to the
//   master. The byte the master received while shifting the previous byte out
//   is collected from D_in and forwarded on the R stream. The last byte of a
//   frame is written with A[1]=1, so the master releases slave-select after
//   it. A closing read strobe, also at A[1]=1, collects the final received
//   byte.
//
// Parameters
//   BASE_ADDR  : I/O address of the SPI master. Bit 1 must be 0, because it
//                is used as the "release slave-select" flag.
//   STROBE_MIN : minimum strobe-low width in cycles. Must be >= 2 so the
//                master's two-flop sampler sees the strobe.
//   GAP        : strobe-high cycles between accesses. Must be >= 3 so the
//                master has raised busy before the next strobe arrives.
//
// Ports
//   CLK        in   system clock, shared with the SPI master
//   RST        in   asynchronous, active-high reset
//   S_DATA     in   [7:0] byte to transmit
//   S_LAST     in   byte ends the frame; slave-select is released after it
//   S_VALID    in   S_DATA/S_LAST valid
//   S_READY    out  byte accepted when S_VALID & S_READY
//   R_DATA     out  [7:0] received byte
//   R_VALID    out  R_DATA valid; held until R_READY
//   R_READY    in   consumer accepts R_DATA
//   A          out  [15:0] address to the master
//   D_out      out  [7:0] write data to the master's D_in
//   D_in       in   [7:0] the master's D_out (continuously driven)
//   IOWR       out  active-low write strobe
//   IORD       out  active-low read strobe
//   WAIT       in   low = master busy while a strobe is low; extends strobe
//   BUSY       out  high whenever the sequencer is not idle
//   state_dbg  out  [2:0] current state, for checkers:
//                   0=IDLE 1=HOLD 2=WR 3=WGAP 4=RD 5=RGAP
//
// Handshakes
//   Both streams use valid/ready: a transfer happens on a rising CLK edge
//   where valid and ready are both high. A source holds valid and its payload
//   stable until that transfer; ready may change freely and does not depend
//   on the same cycle's valid for S_READY. R_VALID, once raised, is held with
//   R_DATA unchanged until R_READY is seen.
// ---------------------------------------------------------------------------
module spi_byte_sequencer #(
  parameter logic [15:0] BASE_ADDR  = 16'h0300,
  parameter int          STROBE_MIN = 3,
  parameter int          GAP        = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [7:0]  S_DATA,
  input  logic        S_LAST,
  input  logic        S_VALID,
  output logic        S_READY,
  output logic [7:0]  R_DATA,
  output logic        R_VALID,
  input  logic        R_READY,
  output logic [15:0] A,
  output logic [7:0]  D_out,
  input  logic [7:0]  D_in,
  output logic        IOWR,
  output logic        IORD,
  input  logic        WAIT,
  output logic        BUSY,
  output logic [2:0]  state_dbg
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,  // no frame open, waiting for the first byte
    ST_HOLD = 3'd1,  // frame open (slave-select low), waiting for next byte
    ST_WR   = 3'd2,  // write strobe low
    ST_WGAP = 3'd3,  // strobes high after a write
    ST_RD   = 3'd4,  // closing read strobe low
    ST_RGAP = 3'd5   // strobes high after the closing read
  } state_t;

  // Last count value of the minimum strobe width and of the gap.
  localparam logic [7:0] STROBE_LAST = 8'(STROBE_MIN - 1);
  localparam logic [7:0] GAP_LAST    = 8'(GAP - 1);

  // Address offsets: bit 1 tells the master to release slave-select.
  localparam logic [15:0] ADDR_RELEASE = 16'h0002;

  state_t      state_q,   state_d;
  logic [7:0]  cnt_q,     cnt_d;
  logic [7:0]  d_out_q,   d_out_d;
  logic        last_q,    last_d;
  logic        pending_q, pending_d;
  logic [7:0]  r_data_q,  r_data_d;
  logic        r_valid_q, r_valid_d;

  logic        s_ready;
  logic        accept;
  logic        r_slot_free;
  logic        strobe_done;

  // Byte acceptance is only possible in the two waiting states.
  assign s_ready = (state_q == ST_IDLE) || (state_q == ST_HOLD);
  assign accept  = S_VALID && s_ready;

  // The R register can take a new byte if it is empty or being popped now.
  assign r_slot_free = !r_valid_q || R_READY;

  // A strobe may end once it has been low long enough and the master no
  // longer holds WAIT low. WAIT high inside a strobe also guarantees that the
  // master's previous transfer has finished, so D_in is the received byte.
  assign strobe_done = (cnt_q >= STROBE_LAST) && WAIT;

  // -------------------------------------------------------------------------
  // Next-state and datapath logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    d_out_d   = d_out_q;
    last_d    = last_q;
    pending_d = pending_q;
    r_data_d  = r_data_q;
    // A pop clears R_VALID; a capture below in the same cycle sets it again.
    r_valid_d = r_valid_q && !R_READY;

    case (state_q)
      ST_IDLE, ST_HOLD: begin
        if (accept) begin
          d_out_d = S_DATA;
          last_d  = S_LAST;
          cnt_d   = 8'd0;
          state_d = ST_WR;
        end
      end

      ST_WR: begin
        // With a byte pending, its capture needs room in the R register;
        // otherwise the strobe is stretched until the consumer pops.
        if (strobe_done && (!pending_q || r_slot_free)) begin
          if (pending_q) begin
            r_data_d  = D_in;
            r_valid_d = 1'b1;
          end
          pending_d = 1'b1;
          cnt_d     = 8'd0;
          state_d   = ST_WGAP;
        end else if (cnt_q < STROBE_LAST) begin
          // Saturate so a long extension cannot wrap the counter.
          cnt_d = cnt_q + 8'd1;
        end
      end

      ST_WGAP: begin
        if (cnt_q >= GAP_LAST) begin
          cnt_d   = 8'd0;
          state_d = last_q ? ST_RD : ST_HOLD;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      ST_RD: begin
        // The closing read always has the last byte's reception pending.
        if (strobe_done && r_slot_free) begin
          r_data_d  = D_in;
          r_valid_d = 1'b1;
          pending_d = 1'b0;
          cnt_d     = 8'd0;
          state_d   = ST_RGAP;
        end else if (cnt_q < STROBE_LAST) begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      ST_RGAP: begin
        if (cnt_q >= GAP_LAST) begin
          cnt_d   = 8'd0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      default: begin
        cnt_d   = 8'd0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 8'd0;
      d_out_q   <= 8'd0;
      last_q    <= 1'b0;
      pending_q <= 1'b0;
      r_data_q  <= 8'd0;
      r_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      d_out_q   <= d_out_d;
      last_q    <= last_d;
      pending_q <= pending_d;
      r_data_q  <= r_data_d;
      r_valid_q <= r_valid_d;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs: strobes and address decode straight from the state register, so
  // a reset raises the strobes immediately and they never glitch on inputs.
  // -------------------------------------------------------------------------
  always_comb begin
    A = BASE_ADDR;
    case (state_q)
      ST_WR:   A = BASE_ADDR | {14'd0, last_q, 1'b0};
      ST_RD:   A = BASE_ADDR | ADDR_RELEASE;
      default: A = BASE_ADDR;
    endcase
  end

  assign IOWR      = (state_q != ST_WR);
  assign IORD      = (state_q != ST_RD);
  assign D_out     = d_out_q;
  assign R_DATA    = r_data_q;
  assign R_VALID   = r_valid_q;
  assign S_READY   = s_ready;
  assign BUSY      = (state_q != ST_IDLE);
  assign state_dbg = state_q;

endmodule

// File: tb/tb_spi_byte_sequencer.sv
// ---------------------------------------------------------------------------
// tb_spi_byte_sequencer
//
// Bench for spi_byte_sequencer. A behavioural SPI master model answers the
// strobes: a write starts a transfer of a programmable length when its
// strobe rises, WAIT is held low while that transfer is in flight and a
// strobe is low, and the byte "received" by the transfer appears on D_in
// when it completes. Expected write accesses, read accesses and R-stream
// bytes come from the bytes the stimulus sends.
// ---------------------------------------------------------------------------
module tb_spi_byte_sequencer;

  localparam logic [15:0] BASE       = 16'h0300;
  localparam int          STROBE_MIN = 3;
  localparam int          GAP        = 4;

  // ---------------- clock / reset and DUT signals ----------------
  logic        clk;
  logic        rst;
  logic [7:0]  s_data;
  logic        s_last;
  logic        s_valid;
  logic        s_ready;
  logic [7:0]  r_data;
  logic        r_valid;
  logic        r_ready;
  logic [15:0] a;
  logic [7:0]  d_out;
  logic [7:0]  d_in;
  logic        iowr;
  logic        iord;
  logic        wait_i;
  logic        busy;
  logic [2:0]  state_dbg;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  spi_byte_sequencer #(
    .BASE_ADDR (BASE),
    .STROBE_MIN(STROBE_MIN),
    .GAP       (GAP)
  ) dut (
    .CLK      (clk),
    .RST      (rst),
    .S_DATA   (s_data),
    .S_LAST   (s_last),
    .S_VALID  (s_valid),
    .S_READY  (s_ready),
    .R_DATA   (r_data),
    .R_VALID  (r_valid),
    .R_READY  (r_ready),
    .A        (a),
    .D_out    (d_out),
    .D_in     (d_in),
    .IOWR     (iowr),
    .IORD     (iord),
    .WAIT     (wait_i),
    .BUSY     (busy),
    .state_dbg(state_dbg)
  );

  // ---------------- SPI master model ----------------
  logic [7:0] miso_arr [256];
  int         len_arr  [256];
  logic       m_busy;
  int         m_cnt;
  int         m_idx;
  logic       m_prev_iowr;
  logic [7:0] m_rx;
  logic       m_ss;
  logic       m_a1;
  logic       m_xfer_last;

  assign wait_i = !(m_busy && (!iowr || !iord));

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy      <= 1'b0;
      m_cnt       <= 0;
      m_idx       <= 0;
      m_prev_iowr <= 1'b1;
      m_rx        <= 8'h00;
      d_in        <= 8'h00;
      m_ss        <= 1'b1;
      m_a1        <= 1'b0;
      m_xfer_last <= 1'b0;
    end else begin
      m_prev_iowr <= iowr;
      if (!iowr) begin
        m_ss <= 1'b0;
        m_a1 <= a[1];
      end
      if (!iord && a[1]) m_ss <= 1'b1;
      if (m_busy) begin
        if (m_cnt <= 1) begin
          m_busy <= 1'b0;
          d_in   <= m_rx;
          if (m_xfer_last) m_ss <= 1'b1;
        end else begin
          m_cnt <= m_cnt - 1;
        end
      end
      if (!m_prev_iowr && iowr) begin
        m_busy      <= 1'b1;
        m_cnt       <= len_arr[m_idx];
        m_rx        <= miso_arr[m_idx];
        m_idx       <= m_idx + 1;
        m_xfer_last <= m_a1;
      end
    end
  end

  // ---------------- R_READY driver ----------------
  int rr_mode;  // 0: always ready, 1: never ready, 2: random
  initial begin
    r_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rr_mode)
        0:       r_ready = 1'b1;
        1:       r_ready = 1'b0;
        default: r_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // ---------------- bus monitor (records accesses and pops) ----------------
  typedef struct {
    logic [15:0] a;
    logic [7:0]  d;
    int          w;
    int          wl;
    bit          stable;
    bit          bp;
  } acc_t;

  acc_t       wr_log[$];
  acc_t       rd_log[$];
  logic [7:0] pop_log[$];
  acc_t       cur_wr;
  acc_t       cur_rd;
  bit         in_wr;
  bit         in_rd;
  logic       prev_rv;
  logic       prev_rr;
  logic [7:0] prev_rd;
  int         r_viol;

  initial r_viol = 0;

  always @(negedge clk) begin
    if (rst) begin
      in_wr   = 1'b0;
      in_rd   = 1'b0;
      prev_rv = 1'b0;
    end else begin
      if (!iowr) begin
        if (!in_wr) begin
          in_wr  = 1'b1;
          cur_wr = '{a: a, d: d_out, w: 0, wl: 0, stable: 1'b1, bp: 1'b0};
        end
        cur_wr.w++;
        if (!wait_i) cur_wr.wl++;
        if (!r_ready) cur_wr.bp = 1'b1;
        if (a !== cur_wr.a || d_out !== cur_wr.d) cur_wr.stable = 1'b0;
      end else if (in_wr) begin
        in_wr = 1'b0;
        wr_log.push_back(cur_wr);
      end
      if (!iord) begin
        if (!in_rd) begin
          in_rd  = 1'b1;
          cur_rd = '{a: a, d: 8'h00, w: 0, wl: 0, stable: 1'b1, bp: 1'b0};
        end
        cur_rd.w++;
        if (!wait_i) cur_rd.wl++;
        if (!r_ready) cur_rd.bp = 1'b1;
        if (a !== cur_rd.a) cur_rd.stable = 1'b0;
      end else if (in_rd) begin
        in_rd = 1'b0;
        rd_log.push_back(cur_rd);
      end
      if (r_valid && r_ready) pop_log.push_back(r_data);
      if (prev_rv && !prev_rr && (r_valid !== 1'b1 || r_data !== prev_rd)) r_viol++;
      prev_rv = r_valid;
      prev_rr = r_ready;
      prev_rd = r_data;
    end
  end

  // ---------------- scoreboard ----------------
  int          errors;
  int          checks;
  logic [23:0] exp_wr_q[$];  // {A, D_out} of each expected write access
  logic [7:0]  exp_q[$];     // expected R-stream bytes
  int          exp_rd_n;
  int          tx_idx;
  int          wr_ptr;
  int          rd_ptr;
  int          pop_ptr;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Offer one byte and wait for it to be accepted; records what the frame
  // must produce: the write access and the byte the master will receive.
  task automatic send_byte(input logic [7:0] d, input logic last,
                           input logic [7:0] miso, input int len);
    int   n;
    logic rdy;
    miso_arr[tx_idx] = miso;
    len_arr[tx_idx]  = len;
    tx_idx++;
    exp_wr_q.push_back({BASE | {14'd0, last, 1'b0}, d});
    exp_q.push_back(miso);
    if (last) exp_rd_n++;
    s_data  = d;
    s_last  = last;
    s_valid = 1'b1;
    n = 0;
    forever begin
      @(negedge clk);
      rdy = s_ready;
      @(posedge clk);
      #1;
      if (rdy) break;
      n++;
      if (n > 5000) begin
        check("accept_timeout", 32'd1, 32'd0);
        break;
      end
    end
    s_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    forever begin
      @(negedge clk);
      if (!busy) break;
      n++;
      if (n > budget) begin
        check("idle_timeout", 32'd1, 32'd0);
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  function automatic int exp_width(input int wl);
    return (wl + 1 > STROBE_MIN) ? wl + 1 : STROBE_MIN;
  endfunction

  task automatic check_logs();
    acc_t        r;
    logic [23:0] e;
    tick(4);
    check("wr_count", 32'(wr_log.size() - wr_ptr), 32'(exp_wr_q.size()));
    while (exp_wr_q.size() > 0 && wr_ptr < wr_log.size()) begin
      e = exp_wr_q.pop_front();
      r = wr_log[wr_ptr];
      wr_ptr++;
      check("wr_addr", 32'(r.a), 32'(e[23:8]));
      check("wr_data", 32'(r.d), 32'(e[7:0]));
      check("wr_stable", 32'(r.stable), 32'd1);
      if (r.bp) check("wr_width_min", 32'(r.w >= STROBE_MIN), 32'd1);
      else      check("wr_width", 32'(r.w), 32'(exp_width(r.wl)));
    end
    exp_wr_q.delete();
    wr_ptr = wr_log.size();
    check("rd_count", 32'(rd_log.size() - rd_ptr), 32'(exp_rd_n));
    while (exp_rd_n > 0 && rd_ptr < rd_log.size()) begin
      r = rd_log[rd_ptr];
      rd_ptr++;
      exp_rd_n--;
      check("rd_addr", 32'(r.a), 32'(BASE | 16'h0002));
      if (r.bp) check("rd_width_min", 32'(r.w >= STROBE_MIN), 32'd1);
      else      check("rd_width", 32'(r.w), 32'(exp_width(r.wl)));
    end
    exp_rd_n = 0;
    rd_ptr   = rd_log.size();
    check("r_count", 32'(pop_log.size() - pop_ptr), 32'(exp_q.size()));
    while (exp_q.size() > 0 && pop_ptr < pop_log.size()) begin
      check("r_data", 32'(pop_log[pop_ptr]), 32'(exp_q.pop_front()));
      pop_ptr++;
    end
    exp_q.delete();
    pop_ptr = pop_log.size();
    check("r_hold", 32'(r_viol), 32'd0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed + random sequence ----------------
  initial begin
    logic       ok;
    logic       ss_ok;
    int         k;
    logic [7:0] b3;

    errors   = 0;
    checks   = 0;
    exp_rd_n = 0;
    tx_idx   = 0;
    wr_ptr   = 0;
    rd_ptr   = 0;
    pop_ptr  = 0;
    rr_mode  = 0;
    rst      = 1'b1;
    s_data   = 8'h00;
    s_last   = 1'b0;
    s_valid  = 1'b0;
    for (int i = 0; i < 256; i++) begin
      miso_arr[i] = 8'h00;
      len_arr[i]  = 2;
    end

    // Reset values.
    tick(3);
    @(negedge clk);
    check("rst_iowr",    32'(iowr),      32'd1);
    check("rst_iord",    32'(iord),      32'd1);
    check("rst_a",       32'(a),         32'(BASE));
    check("rst_d_out",   32'(d_out),     32'd0);
    check("rst_r_data",  32'(r_data),    32'd0);
    check("rst_r_valid", 32'(r_valid),   32'd0);
    check("rst_s_ready", 32'(s_ready),   32'd1);
    check("rst_busy",    32'(busy),      32'd0);
    check("rst_state",   32'(state_dbg), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick(2);

    // 2-byte frame with cycle-level timing of the first strobe.
    send_byte(8'hA5, 1'b0, 8'h5A, 2);
    for (int i = 1; i <= STROBE_MIN + 1; i++) begin
      @(negedge clk);
      check("t1_iowr_cycle", 32'(iowr), (i <= STROBE_MIN) ? 32'd0 : 32'd1);
      if (i == 1) begin
        check("t1_a_first",  32'(a),     32'h0300);
        check("t1_d_first",  32'(d_out), 32'hA5);
        check("t1_s_ready",  32'(s_ready), 32'd0);
        check("t1_busy",     32'(busy),  32'd1);
      end
    end
    @(posedge clk);
    #1;
    send_byte(8'h3C, 1'b1, 8'hC3, 2);
    wait_idle(500);
    check("t1_ss_released", 32'(m_ss), 32'd1);
    check_logs();

    // Single-byte frame.
    send_byte(8'hFF, 1'b1, 8'h00, 3);
    wait_idle(500);
    check_logs();

    // Backpressure: R never ready during a 3-byte frame.
    rr_mode = 1;
    tick(1);
    send_byte(8'h11, 1'b0, 8'hE1, 2);
    send_byte(8'h22, 1'b0, 8'hE2, 2);
    b3 = 8'h33;
    send_byte(b3, 1'b1, 8'hE3, 2);
    tick(20);
    @(negedge clk);
    check("bp_iowr_held", 32'(iowr),    32'd0);
    check("bp_d_out",     32'(d_out),   32'(b3));
    check("bp_a",         32'(a),       32'h0302);
    check("bp_r_valid",   32'(r_valid), 32'd1);
    check("bp_r_data",    32'(r_data),  32'hE1);
    @(posedge clk);
    #1;
    rr_mode = 0;
    wait_idle(500);
    check_logs();

    // Strobe extension: byte 1's transfer keeps the master busy into byte 2.
    send_byte(8'h5D, 1'b0, 8'h77, 50);
    send_byte(8'h6E, 1'b1, 8'h88, 2);
    wait_idle(1000);
    tick(2);
    if (wr_log.size() >= wr_ptr + 2) begin
      check("ext_wait_low", 32'(wr_log[wr_ptr + 1].wl >= 40), 32'd1);
    end else begin
      check("ext_wr_seen", 32'(wr_log.size() - wr_ptr), 32'd2);
    end
    check_logs();

    // Idle within a frame: nothing may happen while no byte is offered.
    send_byte(8'h4B, 1'b0, 8'h99, 2);
    tick(10);
    ok    = 1'b1;
    ss_ok = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!iowr || !iord || !s_ready || !busy) ok = 1'b0;
      if (m_ss) ss_ok = 1'b0;
    end
    @(posedge clk);
    #1;
    check("hold_quiet", 32'(ok),    32'd1);
    check("hold_ss_low", 32'(ss_ok), 32'd1);
    send_byte(8'hB4, 1'b1, 8'h66, 2);
    wait_idle(500);
    check("hold_ss_released", 32'(m_ss), 32'd1);
    check_logs();

    // Reset in the middle of a stretched write strobe with R_VALID high.
    rr_mode = 1;
    tick(1);
    send_byte(8'h01, 1'b0, 8'hD1, 2);
    send_byte(8'h02, 1'b0, 8'hD2, 2);
    send_byte(8'h03, 1'b0, 8'hD3, 2);
    tick(10);
    @(negedge clk);
    check("pre_rst_iowr",    32'(iowr),    32'd0);
    check("pre_rst_r_valid", 32'(r_valid), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_iowr",    32'(iowr),      32'd1);
    check("mid_rst_r_valid", 32'(r_valid),   32'd0);
    check("mid_rst_s_ready", 32'(s_ready),   32'd1);
    check("mid_rst_busy",    32'(busy),      32'd0);
    check("mid_rst_state",   32'(state_dbg), 32'd0);
    tick(2);
    rst     = 1'b0;
    rr_mode = 0;
    exp_wr_q.delete();
    exp_q.delete();
    exp_rd_n = 0;
    tx_idx   = 0;
    tick(2);
    wr_ptr  = wr_log.size();
    rd_ptr  = rd_log.size();
    pop_ptr = pop_log.size();
    send_byte(8'h81, 1'b1, 8'h18, 2);
    wait_idle(500);
    check_logs();

    // Random frames, alternating a ready consumer and a random one.
    for (int f = 0; f < 6; f++) begin
      rr_mode = (f % 2 == 1) ? 2 : 0;
      k = $urandom_range(1, 4);
      for (int i = 0; i < k; i++) begin
        send_byte(8'($urandom), (i == k - 1), 8'($urandom), $urandom_range(1, 12));
      end
      wait_idle(3000);
      rr_mode = 0;
      check_logs();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
